// File: rtl/cp0_unit_pkg.sv
// Shared definitions for the CP0 unit: controller op codes, CP0 register
// numbers and the bit positions of the architected STATUS/CAUSE fields.
package cp0_unit_pkg;

  // CP0 operation requested by the decode controller for the ID instruction
  typedef enum logic [1:0] {
    EXE_CP_NONE  = 2'd0,
    EXE_CP_STORE = 2'd1,  // MTC0
    EXE_CP0_ERET = 2'd2
  } cp_op_e;

  // CP0 register numbers (inst[15:11])
  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;
  localparam logic [4:0] CP0_REG_EBASE  = 5'd25;

  // Implemented bit positions; every other STATUS/CAUSE bit reads 0
  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int CAUSE_IP_BIT   = 8;

  // Build the architectural STATUS word from its implemented fields
  function automatic logic [31:0] pack_status(input logic exl, input logic ie);
    logic [31:0] w;
    w                 = '0;
    w[STATUS_EXL_BIT] = exl;
    w[STATUS_IE_BIT]  = ie;
    return w;
  endfunction

  // Build the architectural CAUSE word from its implemented fields
  function automatic logic [31:0] pack_cause(input logic ip);
    logic [31:0] w;
    w               = '0;
    w[CAUSE_IP_BIT] = ip;
    return w;
  endfunction

endpackage

// File: rtl/cp0_unit_irq_sync.sv
// Synchroniser for the asynchronous external interrupt line followed by a
// rising-edge detector. o_edge is high for one cycle, the cycle after the
// last synchroniser flop rises. SYNC_STAGES must be at least 2.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_irq,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the raw line through the synchroniser and remember the last
  // synchronised level for edge detection.
  // NOTE: flops are written with <= so every stage samples the value the
  // previous stage held before this edge; = here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the 5-stage MIPS pipeline. Holds STATUS/CAUSE/EPC/EBASE,
// serves MFC0 reads, performs MTC0 writes and ERET, and takes the external
// interrupt precisely at the instruction currently in ID by redirecting the
// PC to EBASE (and flushing ID) through jump_en/jump_addr.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] EBASE_RST   = 32'h0000_0008,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  oper,
  input  logic [4:0]  addr_r,
  output logic [31:0] data_r,
  input  logic [4:0]  addr_w,
  input  logic [31:0] data_w,
  input  logic [31:0] pc_id,
  input  logic        irq,
  output logic        jump_en,
  output logic [31:0] jump_addr
);

  // Architectural state
  logic        r_ie;
  logic        r_exl;
  logic        r_ip;
  logic [31:0] r_epc;
  logic [31:0] r_ebase;

  // Decoded control for the current ID instruction
  cp_op_e      w_op;
  logic        w_irq_edge;
  logic        w_eret;
  logic        w_take_int;
  logic        w_mtc0;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic        w_wr_ebase;

  irq_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk    (clk),
    .rst    (rst),
    .i_irq  (irq),
    .o_edge (w_irq_edge)
  );

  assign w_op = cp_op_e'(oper);

  // ERET has top priority; the interrupt is never taken on an ERET cycle so
  // that EPC is consumed before it could be overwritten. A taken interrupt
  // flushes the ID instruction, which squashes any MTC0 it carries.
  assign w_eret      = en & (w_op == EXE_CP0_ERET);
  assign w_take_int  = r_ip & r_ie & ~r_exl & en & (w_op != EXE_CP0_ERET);
  assign w_mtc0      = en & (w_op == EXE_CP_STORE) & ~w_take_int;
  assign w_wr_status = w_mtc0 & (addr_w == CP0_REG_STATUS);
  assign w_wr_cause  = w_mtc0 & (addr_w == CP0_REG_CAUSE);
  assign w_wr_epc    = w_mtc0 & (addr_w == CP0_REG_EPC);
  assign w_wr_ebase  = w_mtc0 & (addr_w == CP0_REG_EBASE);

  // STATUS: ERET leaves the handler, a taken interrupt enters it, MTC0 loads both bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ie  <= 1'b0;
      r_exl <= 1'b0;
    end else if (w_eret) begin
      r_exl <= 1'b0;
    end else if (w_take_int) begin
      r_exl <= 1'b1;
    end else if (w_wr_status) begin
      r_ie  <= data_w[STATUS_IE_BIT];
      r_exl <= data_w[STATUS_EXL_BIT];
    end
  end

  // CAUSE.IP: set by a synchronised edge regardless of en; a fresh edge
  // beats a same-cycle clear so no interrupt is ever lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ip <= 1'b0;
    end else if (w_irq_edge) begin
      r_ip <= 1'b1;
    end else if (w_take_int) begin
      r_ip <= 1'b0;
    end else if (w_wr_cause && !data_w[CAUSE_IP_BIT]) begin
      r_ip <= 1'b0;
    end
  end

  // EPC: captures the ID-stage PC on interrupt entry, or an MTC0 value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_epc <= '0;
    end else if (w_take_int) begin
      r_epc <= pc_id;
    end else if (w_wr_epc) begin
      r_epc <= data_w;
    end
  end

  // EBASE: handler base, software-writable through MTC0 only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ebase <= EBASE_RST;
    end else if (w_wr_ebase) begin
      r_ebase <= data_w;
    end
  end

  // MFC0 read mux from current state; forced to 0 while reset is asserted
  // NOTE: the output is given a default before the case so every path
  // assigns it and no latch is inferred for unlisted addresses.
  always_comb begin
    data_r = '0;
    if (!rst) begin
      case (addr_r)
        CP0_REG_STATUS: data_r = pack_status(r_exl, r_ie);
        CP0_REG_CAUSE:  data_r = pack_cause(r_ip);
        CP0_REG_EPC:    data_r = r_epc;
        CP0_REG_EBASE:  data_r = r_ebase;
        default:        data_r = '0;
      endcase
    end
  end

  // PC redirect: ERET returns to EPC, a taken interrupt vectors to EBASE
  always_comb begin
    jump_en   = 1'b0;
    jump_addr = '0;
    if (!rst) begin
      if (w_eret) begin
        jump_en   = 1'b1;
        jump_addr = r_epc;
      end else if (w_take_int) begin
        jump_en   = 1'b1;
        jump_addr = r_ebase;
      end
    end
  end

endmodule
